// File: rtl/redmule_tile_scheduler.sv
// Walks the M/K/N tile nest (n innermost) and issues one leftover-aware tile descriptor per valid/ready handshake.
// Latency: first descriptor one cycle after start_i, then one per cycle while ready is high. Fields hold while ready is low.
// Optional stall counter on perf_stall_o when REDMULE_TILE_SCHED_PERF_EN is defined; otherwise perf_stall_o is tied to 0.
module redmule_tile_scheduler #(
    parameter int unsigned ARRAY_WIDTH  = 12,
    parameter int unsigned ARRAY_HEIGHT = 4,
    parameter int unsigned PIPE_REGS    = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] x_rows_iter_i,
    input  logic [CNT_W-1:0] w_cols_iter_i,
    input  logic [CNT_W-1:0] x_cols_iter_i,
    input  logic [7:0]       x_rows_lftovr_i,
    input  logic [7:0]       w_cols_lftovr_i,
    input  logic [7:0]       x_cols_lftovr_i,
    output logic             tile_valid_o,
    input  logic             tile_ready_i,
    output logic [CNT_W-1:0] tile_m_idx_o,
    output logic [CNT_W-1:0] tile_k_idx_o,
    output logic [CNT_W-1:0] tile_n_idx_o,
    output logic [7:0]       tile_m_size_o,
    output logic [7:0]       tile_k_size_o,
    output logic [7:0]       tile_n_size_o,
    output logic             tile_store_o,
    output logic             tile_last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      perf_stall_o
);

    localparam logic [7:0]       M_FULL  = 8'(ARRAY_WIDTH);
    localparam logic [7:0]       KN_FULL = 8'(ARRAY_HEIGHT * (PIPE_REGS + 1));
    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] xr_q, wc_q, xc_q, m_q, k_q, n_q;
    logic [7:0]       lm_q, lk_q, ln_q, m_sz_q, k_sz_q, n_sz_q;
    logic             valid_q, store_q, last_q, busy_q, done_q;

    logic [CNT_W-1:0] xr_d, wc_d, xc_d, m_d, k_d, n_d;
    logic [7:0]       lm_d, lk_d, ln_d, m_sz_d, k_sz_d, n_sz_d;
    logic             store_d, last_d, n_wrap, k_wrap, cnt_zero, hs, load;

    // Next descriptor: indices 0 from the live inputs when starting, else the advanced nest on the latched counts.
    always_comb begin
        hs       = valid_q & tile_ready_i;
        n_wrap   = (n_q == xc_q - ONE);
        k_wrap   = (k_q == wc_q - ONE);
        cnt_zero = (x_rows_iter_i == '0) | (w_cols_iter_i == '0) | (x_cols_iter_i == '0);
        load     = ((state_q == IDLE) & start_i & ~cnt_zero) | ((state_q == RUN) & hs & ~last_q);
        if (state_q == IDLE) begin
            xr_d = x_rows_iter_i;
            wc_d = w_cols_iter_i;
            xc_d = x_cols_iter_i;
            lm_d = x_rows_lftovr_i;
            lk_d = w_cols_lftovr_i;
            ln_d = x_cols_lftovr_i;
            m_d  = '0;
            k_d  = '0;
            n_d  = '0;
        end else begin
            xr_d = xr_q;
            wc_d = wc_q;
            xc_d = xc_q;
            lm_d = lm_q;
            lk_d = lk_q;
            ln_d = ln_q;
            n_d  = n_wrap ? '0 : n_q + ONE;
            k_d  = n_wrap ? (k_wrap ? '0 : k_q + ONE) : k_q;
            m_d  = (n_wrap & k_wrap) ? m_q + ONE : m_q;
        end
        m_sz_d  = ((m_d == xr_d - ONE) && (lm_d != '0)) ? lm_d : M_FULL;
        k_sz_d  = ((k_d == wc_d - ONE) && (lk_d != '0)) ? lk_d : KN_FULL;
        n_sz_d  = ((n_d == xc_d - ONE) && (ln_d != '0)) ? ln_d : KN_FULL;
        store_d = (n_d == xc_d - ONE);
        last_d  = store_d & (k_d == wc_d - ONE) & (m_d == xr_d - ONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            xr_q    <= '0;
            wc_q    <= '0;
            xc_q    <= '0;
            lm_q    <= '0;
            lk_q    <= '0;
            ln_q    <= '0;
            m_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
            m_sz_q  <= '0;
            k_sz_q  <= '0;
            n_sz_q  <= '0;
            store_q <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (clear_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (cnt_zero) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            valid_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (hs && last_q) begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
            if (load) begin
                xr_q    <= xr_d;
                wc_q    <= wc_d;
                xc_q    <= xc_d;
                lm_q    <= lm_d;
                lk_q    <= lk_d;
                ln_q    <= ln_d;
                m_q     <= m_d;
                k_q     <= k_d;
                n_q     <= n_d;
                m_sz_q  <= m_sz_d;
                k_sz_q  <= k_sz_d;
                n_sz_q  <= n_sz_d;
                store_q <= store_d;
                last_q  <= last_d;
            end
        end
    end

    assign tile_valid_o  = valid_q;
    assign tile_m_idx_o  = m_q;
    assign tile_k_idx_o  = k_q;
    assign tile_n_idx_o  = n_q;
    assign tile_m_size_o = m_sz_q;
    assign tile_k_size_o = k_sz_q;
    assign tile_n_size_o = n_sz_q;
    assign tile_store_o  = store_q;
    assign tile_last_o   = last_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

`ifdef REDMULE_TILE_SCHED_PERF_EN
    logic [31:0] stall_q;

    // Saturating count of cycles where a descriptor waits on the consumer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (clear_i || (start_i && (state_q == IDLE))) begin
            stall_q <= '0;
        end else if (valid_q && !tile_ready_i && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_stall_o = stall_q;
`else
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_redmule_tile_scheduler.sv
// Bench for redmule_tile_scheduler: table of job configurations plus random jobs, each checked against
// a loop-nest model of the descriptor stream, and hand-written sequences for clear, zero-count and reset.
module tb_redmule_tile_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        start_i = 1'b0;
    logic        tile_ready_i = 1'b0;
    logic [15:0] x_rows_iter_i = '0, w_cols_iter_i = '0, x_cols_iter_i = '0;
    logic [7:0]  x_rows_lftovr_i = '0, w_cols_lftovr_i = '0, x_cols_lftovr_i = '0;
    logic        tile_valid_o, tile_store_o, tile_last_o, busy_o, done_o;
    logic [15:0] tile_m_idx_o, tile_k_idx_o, tile_n_idx_o;
    logic [7:0]  tile_m_size_o, tile_k_size_o, tile_n_size_o;
    logic [31:0] perf_stall_o;

    int checks = 0;
    int errors = 0;

    redmule_tile_scheduler dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .x_rows_iter_i(x_rows_iter_i), .w_cols_iter_i(w_cols_iter_i), .x_cols_iter_i(x_cols_iter_i),
        .x_rows_lftovr_i(x_rows_lftovr_i), .w_cols_lftovr_i(w_cols_lftovr_i), .x_cols_lftovr_i(x_cols_lftovr_i),
        .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
        .tile_m_idx_o(tile_m_idx_o), .tile_k_idx_o(tile_k_idx_o), .tile_n_idx_o(tile_n_idx_o),
        .tile_m_size_o(tile_m_size_o), .tile_k_size_o(tile_k_size_o), .tile_n_size_o(tile_n_size_o),
        .tile_store_o(tile_store_o), .tile_last_o(tile_last_o),
        .busy_o(busy_o), .done_o(done_o), .perf_stall_o(perf_stall_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] xr, wc, xc;
        logic [7:0]  lm, lk, ln;
        int          exp_desc;
        int          exp_store;
        int          rdy_pct;
    } vec_t;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] dut_desc();
        return {6'b0, tile_m_idx_o, tile_k_idx_o, tile_n_idx_o,
                tile_m_size_o, tile_k_size_o, tile_n_size_o, tile_store_o, tile_last_o};
    endfunction

    function automatic logic [7:0] eff(input int idx, input int iters, input logic [7:0] lft, input logic [7:0] full);
        return (idx == iters - 1 && lft != 8'd0) ? lft : full;
    endfunction

    task automatic set_cfg(input vec_t c);
        x_rows_iter_i = c.xr;  w_cols_iter_i = c.wc;  x_cols_iter_i = c.xc;
        x_rows_lftovr_i = c.lm; w_cols_lftovr_i = c.lk; x_cols_lftovr_i = c.ln;
    endtask

    // Runs one job from IDLE, called right after a falling edge.
    task automatic run_job(input vec_t c, input int stall_idx, input int stall_len, input int busy_start_idx,
                           output int n_hs, output int n_st, output int n_cyc);
        logic [79:0] exp_q[$];
        int idx, held, stalls, cyc;
        int xr, wc, xc;
        bit rdy, injected;
        xr = int'(c.xr); wc = int'(c.wc); xc = int'(c.xc);
        for (int m = 0; m < xr; m++)
            for (int k = 0; k < wc; k++)
                for (int n = 0; n < xc; n++)
                    exp_q.push_back({6'b0, 16'(m), 16'(k), 16'(n),
                                     eff(m, xr, c.lm, 8'd12), eff(k, wc, c.lk, 8'd16), eff(n, xc, c.ln, 8'd16),
                                     1'(n == xc - 1), 1'(n == xc - 1 && k == wc - 1 && m == xr - 1)});
        set_cfg(c);
        start_i = 1'b1;
        tile_ready_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        idx = 0; held = 0; stalls = 0; cyc = 0; n_st = 0; injected = 0;
        while (idx < exp_q.size() && cyc < 2000) begin
            chk("valid_in_run", {79'b0, tile_valid_o}, 80'd1);
            if (tile_valid_o !== 1'b1) break;
            chk("desc", dut_desc(), exp_q[idx]);
            if (idx == stall_idx && held < stall_len) begin
                rdy = 1'b0;
                held++;
            end else begin
                rdy = ($urandom_range(99) < c.rdy_pct);
            end
            tile_ready_i = rdy;
            if (!rdy) stalls++;
            if (idx == busy_start_idx && !injected) begin
                start_i = 1'b1;
                x_rows_iter_i = 16'd1; w_cols_iter_i = 16'd5; x_cols_iter_i = 16'd0;
                injected = 1;
            end else begin
                start_i = 1'b0;
            end
            if (rdy && tile_store_o === 1'b1) n_st++;
            @(negedge clk_i);
            cyc++;
            if (rdy) idx++;
        end
        tile_ready_i = 1'b0;
        start_i = 1'b0;
        if (idx < exp_q.size()) chk("job_timeout", 80'(idx), 80'(exp_q.size()));
        chk("done_pulse", {77'b0, done_o, busy_o, tile_valid_o}, 80'b110);
`ifdef REDMULE_TILE_SCHED_PERF_EN
        chk("perf_stall", 80'(perf_stall_o), 80'(stalls));
`else
        chk("perf_stall", 80'(perf_stall_o), 80'd0);
`endif
        @(negedge clk_i);
        chk("after_done", {77'b0, done_o, busy_o, tile_valid_o}, 80'b000);
        n_hs = idx;
        n_cyc = cyc;
    endtask

    initial begin
        vec_t tbl[5];
        vec_t basic, rc;
        int hs, st, cyc;

        tbl[0] = '{16'd2, 16'd2, 16'd3, 8'd0, 8'd0, 8'd0,  12, 4, 100};
        tbl[1] = '{16'd2, 16'd1, 16'd2, 8'd5, 8'd7, 8'd3,   4, 2, 100};
        tbl[2] = '{16'd1, 16'd1, 16'd1, 8'd0, 8'd0, 8'd0,   1, 1, 60};
        tbl[3] = '{16'd3, 16'd1, 16'd4, 8'd1, 8'd15, 8'd9, 12, 3, 70};
        tbl[4] = '{16'd1, 16'd3, 16'd1, 8'd11, 8'd0, 8'd2,  3, 3, 50};
        basic  = tbl[0];

        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("reset_ctrl", {75'b0, tile_valid_o, busy_o, done_o, tile_store_o, tile_last_o}, 80'd0);
        chk("reset_desc", dut_desc(), 80'd0);
        chk("reset_perf", 80'(perf_stall_o), 80'd0);

        for (int i = 0; i < 5; i++) begin
            run_job(tbl[i], -1, 0, -1, hs, st, cyc);
            chk("tbl_desc_count", 80'(hs), 80'(tbl[i].exp_desc));
            chk("tbl_store_count", 80'(st), 80'(tbl[i].exp_store));
            if (tbl[i].rdy_pct == 100) chk("tbl_b2b_cycles", 80'(cyc), 80'(tbl[i].exp_desc));
        end

        // Backpressure on descriptor 3 for four cycles.
        run_job(basic, 3, 4, -1, hs, st, cyc);
        chk("bp_cycles", 80'(cyc), 80'd16);

        // Start pulse with other counts while running must be ignored.
        run_job(basic, -1, 0, 2, hs, st, cyc);
        chk("busy_start_count", 80'(hs), 80'd12);

        // Zero iteration count.
        rc = basic;
        rc.xc = 16'd0;
        set_cfg(rc);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("zero_done", {77'b0, done_o, busy_o, tile_valid_o}, 80'b110);
        @(negedge clk_i);
        chk("zero_after", {77'b0, done_o, busy_o, tile_valid_o}, 80'b000);
        @(negedge clk_i);
        chk("zero_no_valid", {79'b0, tile_valid_o}, 80'd0);

        // Clear while descriptor 5 is pending.
        set_cfg(basic);
        start_i = 1'b1;
        tile_ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("clr_pending_desc", dut_desc(), {6'b0, 16'd0, 16'd1, 16'd2, 8'd12, 8'd16, 8'd16, 1'b1, 1'b0});
        tile_ready_i = 1'b0;
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk("clr_state", {77'b0, tile_valid_o, busy_o, done_o}, 80'd0);
        chk("clr_perf", 80'(perf_stall_o), 80'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("clr_no_done", {78'b0, done_o, tile_valid_o}, 80'd0);
        end
        rc = basic;
        rc.rdy_pct = 60;
        run_job(rc, -1, 0, -1, hs, st, cyc);
        chk("restart_count", 80'(hs), 80'd12);

        // Clear and start together: clear wins.
        set_cfg(basic);
        start_i = 1'b1;
        clear_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        clear_i = 1'b0;
        chk("clr_start", {77'b0, tile_valid_o, busy_o, done_o}, 80'd0);

        // Asynchronous reset mid-job.
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_ctrl", {77'b0, tile_valid_o, busy_o, done_o}, 80'd0);
        chk("arst_desc", dut_desc(), 80'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int r = 0; r < 8; r++) begin
            rc.xr = 16'($urandom_range(1, 3));
            rc.wc = 16'($urandom_range(1, 3));
            rc.xc = 16'($urandom_range(1, 4));
            rc.lm = 8'($urandom_range(0, 11));
            rc.lk = 8'($urandom_range(0, 15));
            rc.ln = 8'($urandom_range(0, 15));
            rc.exp_desc  = int'(rc.xr) * int'(rc.wc) * int'(rc.xc);
            rc.exp_store = int'(rc.xr) * int'(rc.wc);
            rc.rdy_pct   = int'($urandom_range(30, 100));
            run_job(rc, -1, 0, -1, hs, st, cyc);
            chk("rand_desc_count", 80'(hs), 80'(rc.exp_desc));
            chk("rand_store_count", 80'(st), 80'(rc.exp_store));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/redmule_tile_scheduler.md
# redmule_tile_scheduler

Tile scheduler for the RedMulE datapath. It consumes the iteration counts and leftovers computed by the tiler once the tiler's valid rises, walks the X-row / W-column / X-column loop nest, and issues one tile descriptor per handshake to the streamer/controller. Each descriptor carries loop indices, effective tile sizes (leftover-aware) and end-of-accumulation / end-of-job markers.

## Interface

Parameters:

- ARRAY_WIDTH, default 12: rows per X tile (full tile height).
- ARRAY_HEIGHT, default 4: computing-element rows.
- PIPE_REGS, default 3: FMA pipeline depth. Full column tile is ARRAY_HEIGHT*(PIPE_REGS+1).
- CNT_W, default 16: width of every iteration counter and index.

Ports (one clock; reset is asynchronous and active-low):

- clk_i, input, 1: clock.
- rst_ni, input, 1: asynchronous active-low reset.
- clear_i, input, 1: synchronous clear to IDLE; overrides all other inputs.
- start_i, input, 1: one-cycle pulse, aligned with the tiler valid. Configuration is sampled on this cycle.
- x_rows_iter_i, input, CNT_W: X row iterations (M tiles).
- w_cols_iter_i, input, CNT_W: W column iterations (K tiles).
- x_cols_iter_i, input, CNT_W: X column iterations (N tiles).
- x_rows_lftovr_i, input, 8: rows in the last M tile; 0 means full.
- w_cols_lftovr_i, input, 8: columns in the last K tile; 0 means full.
- x_cols_lftovr_i, input, 8: columns in the last N tile; 0 means full.
- tile_valid_o, output, 1: descriptor valid.
- tile_ready_i, input, 1: consumer accepts the descriptor.
- tile_m_idx_o, output, CNT_W: current row-tile index.
- tile_k_idx_o, output, CNT_W: current W-column-tile index.
- tile_n_idx_o, output, CNT_W: current X-column-tile index.
- tile_m_size_o, output, 8: effective rows.
- tile_k_size_o, output, 8: effective W columns.
- tile_n_size_o, output, 8: effective X columns.
- tile_store_o, output, 1: last N tile of the current (m,k). The Z tile completes after this tile.
- tile_last_o, output, 1: final descriptor of the job.
- busy_o, output, 1: high in RUN and DONE.
- done_o, output, 1: one-cycle pulse at job end.
- perf_stall_o, output, 32: stall-cycle counter (see Configuration).

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on start_i when all three iteration counts are nonzero. Counts and leftovers are latched into internal registers, and all indices reset to 0.
- IDLE → DONE on start_i when any iteration count is 0. No descriptor is issued.
- start_i is ignored in RUN and DONE.
- RUN:
  - tile_valid_o is 1.
  - On tile_valid_o & tile_ready_i the nest advances. n is innermost, then k, then m.
  - n wraps to 0 at x_cols_iter-1 and increments k. k wraps at w_cols_iter-1 and increments m.
  - The handshake on the descriptor with tile_last_o = 1 moves the FSM to DONE.
- DONE: done_o = 1 for exactly one cycle, then IDLE.
- Effective sizes:
  - tile_m_size_o = x_rows_lftovr when m is last and the leftover is nonzero; otherwise ARRAY_WIDTH.
  - tile_k_size_o and tile_n_size_o follow the same rule, using full size ARRAY_HEIGHT*(PIPE_REGS+1).
- tile_store_o = (n == x_cols_iter-1).
- tile_last_o = tile_store_o & (k == w_cols_iter-1) & (m == x_rows_iter-1).
- Index arithmetic is unsigned CNT_W. No overflow is possible because indices are bounded by the latched counts.
- The total number of handshakes with tile_store_o = 1 equals x_rows_iter*w_cols_iter, which matches the tiler's tot_stores.

## Timing

- Reset values: tile_valid_o = 0. All indices, sizes, tile_store_o, tile_last_o, busy_o, done_o and perf_stall_o = 0. FSM in IDLE.
- All outputs are registered.
- tile_valid_o rises on the cycle after start_i (latency 1).
- With ready held high, one descriptor is issued per cycle.
- While tile_valid_o = 1 and tile_ready_i = 0, every descriptor field holds stable. Valid never drops without a handshake.
- done_o asserts the cycle after the last handshake; busy_o falls the cycle after that.
- For a zero-count start: done_o asserts 1 cycle after start_i, and tile_valid_o stays 0.
- clear_i, including mid-RUN with valid pending: on the next edge go to IDLE, and tile_valid_o = 0, busy_o = 0, done_o = 0. The pending descriptor is dropped. perf_stall_o is cleared.
- clear_i and start_i in the same cycle: clear wins and the FSM stays in IDLE.
- Asynchronous reset mid-operation: immediate return to reset values.

## Configuration

- REDMULE_TILE_SCHED_PERF_EN defined:
  - perf_stall_o counts cycles with tile_valid_o & ~tile_ready_i.
  - It is cleared on start_i, clear_i and reset, and saturates at 2^32-1.
- Macro undefined: perf_stall_o is tied to 0 and no counter register is synthesized.

## Test plan

- Basic nest: counts (2,2,3), leftovers 0, ready always high.
  - Expect 12 descriptors on consecutive cycles in n-fastest order.
  - tile_store_o on 4 of them; tile_last_o only on (1,1,2).
  - done_o one cycle after the last descriptor.
- Leftovers: counts (2,1,2), leftovers (5,7,3), with defaults.
  - m = 1 tiles: m_size 5; m = 0 tiles: m_size 12.
  - k_size 7 on all tiles.
  - n = 1 tiles: n_size 3; n = 0 tiles: n_size 16.
- Backpressure: ready low for 4 cycles on descriptor 3.
  - Fields stay stable and valid stays high.
  - Sequence resumes unchanged.
  - With the PERF macro, perf_stall_o = 4.
- Zero count: x_cols_iter = 0.
  - No tile_valid_o.
  - done_o pulses 1 cycle after start_i; busy_o high for that cycle only.
- Clear mid-job: clear_i during descriptor 5 with ready low.
  - Valid drops the next cycle, there is no done_o, and busy_o = 0.
  - A new start_i restarts at index (0,0,0).
- Start while busy: start_i pulse with different counts during RUN.
  - Ignored; the original sequence completes intact.
